// File: rtl/idu_stage.sv
// RV32I/RV64I integer decode stage: valid/ready input, one registered output slot.
// Define IDU_SKID_EN to add a one-entry skid buffer that registers in_ready.
module idu_stage #(
    parameter int DATA_LEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         inst,
    input  logic [DATA_LEN-1:0] pc,
    output logic [4:0]          rs1,
    output logic [4:0]          rs2,
    input  logic [DATA_LEN-1:0] src1,
    input  logic [DATA_LEN-1:0] src2,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4:0]          rd,
    output logic [DATA_LEN-1:0] operand1,
    output logic [DATA_LEN-1:0] operand2,
    output logic [3:0]          alu_op,
    output logic [DATA_LEN-1:0] imm,
    output logic [DATA_LEN-1:0] out_pc,
    output logic                wb_en,
    output logic                is_jump,
    output logic                ebreak,
    output logic                illegal
);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_OP_IMM = 7'b0010011,
        OPC_OP     = 7'b0110011,
        OPC_SYSTEM = 7'b1110011
    } opcode_e;

    typedef struct packed {
        logic [4:0]          rd;
        logic [DATA_LEN-1:0] op1;
        logic [DATA_LEN-1:0] op2;
        alu_op_e             alu_op;
        logic [DATA_LEN-1:0] imm;
        logic [DATA_LEN-1:0] pc;
        logic                wb_en;
        logic                is_jump;
        logic                ebreak;
        logic                illegal;
    } dec_t;

    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [DATA_LEN-1:0] imm_i;
    logic [DATA_LEN-1:0] imm_u;
    logic [DATA_LEN-1:0] imm_j;
    logic [DATA_LEN-1:0] shamt;
    logic                sl_ok;
    logic                sr_ok;
    logic                legal;
    dec_t                dec;

    dec_t out_q, out_d;
    logic out_valid_q, out_valid_d;
    logic accept;

    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    assign imm_i = DATA_LEN'($signed(inst[31:20]));
    assign imm_u = DATA_LEN'($signed({inst[31:12], 12'h000}));
    assign imm_j = DATA_LEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

    // RV64 uses a 6-bit shamt, so inst[25] is only a funct bit on RV32.
    always_comb begin
        if (DATA_LEN == 64) begin
            shamt = DATA_LEN'(inst[25:20]);
            sl_ok = (inst[31:26] == 6'b000000);
            sr_ok = (inst[31:26] == 6'b000000) || (inst[31:26] == 6'b010000);
        end else begin
            shamt = DATA_LEN'(inst[24:20]);
            sl_ok = (inst[31:25] == 7'b0000000);
            sr_ok = (inst[31:25] == 7'b0000000) || (inst[31:25] == 7'b0100000);
        end
    end

    always_comb begin
        dec        = '0;
        dec.pc     = pc;
        dec.rd     = inst[11:7];
        dec.alu_op = ALU_ADD;
        legal      = 1'b1;
        case (opcode_e'(inst[6:0]))
            OPC_LUI: begin
                dec.op2 = imm_u;
                dec.imm = imm_u;
            end
            OPC_AUIPC: begin
                dec.op1 = pc;
                dec.op2 = imm_u;
                dec.imm = imm_u;
            end
            OPC_JAL: begin
                dec.op1     = pc;
                dec.op2     = DATA_LEN'(3'd4);
                dec.imm     = imm_j;
                dec.is_jump = 1'b1;
            end
            OPC_JALR: begin
                dec.op1     = pc;
                dec.op2     = DATA_LEN'(3'd4);
                dec.imm     = imm_i;
                dec.is_jump = 1'b1;
                legal       = (funct3 == 3'b000);
            end
            OPC_OP_IMM: begin
                dec.op1 = src1;
                dec.op2 = imm_i;
                dec.imm = imm_i;
                case (funct3)
                    3'b000: dec.alu_op = ALU_ADD;
                    3'b010: dec.alu_op = ALU_SLT;
                    3'b011: dec.alu_op = ALU_SLTU;
                    3'b100: dec.alu_op = ALU_XOR;
                    3'b110: dec.alu_op = ALU_OR;
                    3'b111: dec.alu_op = ALU_AND;
                    3'b001: begin
                        dec.alu_op = ALU_SLL;
                        dec.op2    = shamt;
                        legal      = sl_ok;
                    end
                    default: begin
                        dec.alu_op = inst[30] ? ALU_SRA : ALU_SRL;
                        dec.op2    = shamt;
                        legal      = sr_ok;
                    end
                endcase
            end
            OPC_OP: begin
                dec.op1 = src1;
                dec.op2 = src2;
                if (funct7 == 7'h00) begin
                    case (funct3)
                        3'b000:  dec.alu_op = ALU_ADD;
                        3'b001:  dec.alu_op = ALU_SLL;
                        3'b010:  dec.alu_op = ALU_SLT;
                        3'b011:  dec.alu_op = ALU_SLTU;
                        3'b100:  dec.alu_op = ALU_XOR;
                        3'b101:  dec.alu_op = ALU_SRL;
                        3'b110:  dec.alu_op = ALU_OR;
                        default: dec.alu_op = ALU_AND;
                    endcase
                end else if (funct7 == 7'h20 && funct3 == 3'b000) begin
                    dec.alu_op = ALU_SUB;
                end else if (funct7 == 7'h20 && funct3 == 3'b101) begin
                    dec.alu_op = ALU_SRA;
                end else begin
                    legal = 1'b0;
                end
            end
            OPC_SYSTEM: begin
                if (inst == 32'h0010_0073) begin
                    dec.ebreak = 1'b1;
                end else begin
                    legal = 1'b0;
                end
            end
            default: legal = 1'b0;
        endcase

        // Illegal encodings present a neutral, non-writing ADD of zeros.
        if (!legal) begin
            dec.op1     = '0;
            dec.op2     = '0;
            dec.imm     = '0;
            dec.alu_op  = ALU_ADD;
            dec.is_jump = 1'b0;
            dec.ebreak  = 1'b0;
            dec.illegal = 1'b1;
        end
        dec.wb_en = legal && !dec.ebreak && (dec.rd != 5'd0);
    end

`ifdef IDU_SKID_EN
    dec_t skid_q, skid_d;
    logic skid_valid_q, skid_valid_d;
    logic out_free;

    assign in_ready = !skid_valid_q;
    assign accept   = in_valid && in_ready && !flush;
    assign out_free = !out_valid_q || out_ready;

    // A held skid entry always drains ahead of new input, preserving order.
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            if (out_free) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (out_free) begin
                out_d       = dec;
                out_valid_d = 1'b1;
            end else begin
                skid_d       = dec;
                skid_valid_d = 1'b1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end
`else
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_d       = dec;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign rd        = out_q.rd;
    assign operand1  = out_q.op1;
    assign operand2  = out_q.op2;
    assign alu_op    = out_q.alu_op;
    assign imm       = out_q.imm;
    assign out_pc    = out_q.pc;
    assign wb_en     = out_q.wb_en;
    assign is_jump   = out_q.is_jump;
    assign ebreak    = out_q.ebreak;
    assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_idu_stage.sv
// Directed bench for idu_stage (DATA_LEN=32); honours IDU_SKID_EN for the stall scenario.
module tb_idu_stage;
    localparam int DL = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   inst;
    logic [DL-1:0] pc;
    logic [4:0]    rs1, rs2;
    logic [DL-1:0] src1, src2;
    logic          out_valid;
    logic          out_ready;
    logic [4:0]    rd;
    logic [DL-1:0] operand1, operand2;
    logic [3:0]    alu_op;
    logic [DL-1:0] imm;
    logic [DL-1:0] out_pc;
    logic          wb_en, is_jump, ebreak, illegal;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    idu_stage #(.DATA_LEN(DL)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .inst(inst), .pc(pc), .rs1(rs1), .rs2(rs2),
        .src1(src1), .src2(src2),
        .out_valid(out_valid), .out_ready(out_ready),
        .rd(rd), .operand1(operand1), .operand2(operand2),
        .alu_op(alu_op), .imm(imm), .out_pc(out_pc),
        .wb_en(wb_en), .is_jump(is_jump), .ebreak(ebreak), .illegal(illegal)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] i, input logic [DL-1:0] p,
                         input logic [DL-1:0] s1, input logic [DL-1:0] s2);
        inst = i; pc = p; src1 = s1; src2 = s2; in_valid = 1'b1;
    endtask

    task automatic idle();
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        inst = '0; pc = '0; src1 = '0; src2 = '0;
        #12;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        total++; if ({operand1, operand2, imm, out_pc} !== '0) begin bad++; $display("FAIL rst_data got=%h/%h/%h/%h exp=0", operand1, operand2, imm, out_pc); end
        total++; if ({rd, alu_op, wb_en, is_jump, ebreak, illegal} !== '0) begin bad++; $display("FAIL rst_ctrl got=%h/%h/%b%b%b%b exp=0", rd, alu_op, wb_en, is_jump, ebreak, illegal); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_addi();
        idle();
        offer(32'hFFF1_0093, 32'h1000, 32'd5, 32'd7);
        #1;
        total++; if (rs1 !== 5'd2 || rs2 !== 5'd31) begin bad++; $display("FAIL addi_rs got=%0d/%0d exp=2/31", rs1, rs2); end
        step(); in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL addi_valid got=%b exp=1", out_valid); end
        total++; if (operand1 !== 32'd5 || operand2 !== 32'hFFFF_FFFF) begin bad++; $display("FAIL addi_ops got=%h/%h exp=00000005/ffffffff", operand1, operand2); end
        total++; if (alu_op !== 4'd0 || rd !== 5'd1 || wb_en !== 1'b1) begin bad++; $display("FAIL addi_ctrl got=%0d/%0d/%b exp=0/1/1", alu_op, rd, wb_en); end
        total++; if (imm !== 32'hFFFF_FFFF || out_pc !== 32'h1000) begin bad++; $display("FAIL addi_imm_pc got=%h/%h exp=ffffffff/00001000", imm, out_pc); end
    endtask

    task automatic test_lui_sub();
        idle();
        offer(32'h1234_52B7, 32'h0, 32'hAAAA, 32'hBBBB);
        step(); in_valid = 1'b0;
        total++; if (operand1 !== 32'd0 || operand2 !== 32'h1234_5000) begin bad++; $display("FAIL lui_ops got=%h/%h exp=00000000/12345000", operand1, operand2); end
        total++; if (rd !== 5'd5 || wb_en !== 1'b1 || alu_op !== 4'd0) begin bad++; $display("FAIL lui_ctrl got=%0d/%b/%0d exp=5/1/0", rd, wb_en, alu_op); end
        idle();
        offer(32'h4020_81B3, 32'h0, 32'd9, 32'd4);
        step(); in_valid = 1'b0;
        total++; if (alu_op !== 4'd1 || operand1 !== 32'd9 || operand2 !== 32'd4) begin bad++; $display("FAIL sub got=%0d/%h/%h exp=1/9/4", alu_op, operand1, operand2); end
        total++; if (rd !== 5'd3 || wb_en !== 1'b1 || illegal !== 1'b0) begin bad++; $display("FAIL sub_ctrl got=%0d/%b/%b exp=3/1/0", rd, wb_en, illegal); end
    endtask

    task automatic test_srai();
        idle();
        offer(32'h4031_D213, 32'h0, 32'h8000_0000, 32'h0);
        step(); in_valid = 1'b0;
        total++; if (alu_op !== 4'd7 || operand1 !== 32'h8000_0000 || operand2 !== 32'd3) begin bad++; $display("FAIL srai got=%0d/%h/%h exp=7/80000000/3", alu_op, operand1, operand2); end
        total++; if (rd !== 5'd4 || wb_en !== 1'b1) begin bad++; $display("FAIL srai_ctrl got=%0d/%b exp=4/1", rd, wb_en); end
    endtask

    task automatic test_back_to_back();
        idle();
        offer(32'hFFF1_0093, 32'h0FC, 32'd1, 32'd0);
        step();
        total++; if (out_valid !== 1'b1 || operand1 !== 32'd1) begin bad++; $display("FAIL b2b_first got=%b/%h exp=1/1", out_valid, operand1); end
        offer(32'h0080_00EF, 32'h100, 32'd0, 32'd0);
        step(); in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || operand1 !== 32'h100 || operand2 !== 32'd4) begin bad++; $display("FAIL jal_ops got=%b/%h/%h exp=1/100/4", out_valid, operand1, operand2); end
        total++; if (is_jump !== 1'b1 || imm !== 32'd8 || rd !== 5'd1 || wb_en !== 1'b1) begin bad++; $display("FAIL jal_ctrl got=%b/%h/%0d/%b exp=1/8/1/1", is_jump, imm, rd, wb_en); end
    endtask

    task automatic test_ebreak_illegal();
        idle();
        offer(32'h0010_0073, 32'h0, 32'd0, 32'd0);
        step(); in_valid = 1'b0;
        total++; if (ebreak !== 1'b1 || wb_en !== 1'b0 || illegal !== 1'b0) begin bad++; $display("FAIL ebreak got=%b/%b/%b exp=1/0/0", ebreak, wb_en, illegal); end
        idle();
        offer(32'hFFFF_FFFF, 32'h44, 32'h55, 32'h66);
        step(); in_valid = 1'b0;
        total++; if (illegal !== 1'b1 || wb_en !== 1'b0 || is_jump !== 1'b0 || alu_op !== 4'd0) begin bad++; $display("FAIL ill_ctrl got=%b/%b/%b/%0d exp=1/0/0/0", illegal, wb_en, is_jump, alu_op); end
        total++; if (operand1 !== 32'd0 || operand2 !== 32'd0 || imm !== 32'd0) begin bad++; $display("FAIL ill_ops got=%h/%h/%h exp=0/0/0", operand1, operand2, imm); end
        idle();
        offer(32'h0200_9093, 32'h0, 32'd1, 32'd0);
        step(); in_valid = 1'b0;
        total++; if (illegal !== 1'b1 || wb_en !== 1'b0) begin bad++; $display("FAIL slli32 got=%b/%b exp=1/0", illegal, wb_en); end
        idle();
        offer(32'h0220_81B3, 32'h0, 32'd3, 32'd4);
        step(); in_valid = 1'b0;
        total++; if (illegal !== 1'b1 || operand1 !== 32'd0) begin bad++; $display("FAIL mul got=%b/%h exp=1/0", illegal, operand1); end
    endtask

    task automatic test_stall();
        logic exp_rdy;
        idle();
        out_ready = 1'b0;
        offer(32'hFFF1_0093, 32'h0, 32'd10, 32'd0);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_rdy0 got=%b exp=1", in_ready); end
        step();
        for (int c = 0; c < 3; c++) begin
`ifdef IDU_SKID_EN
            exp_rdy = (c == 0);
            if (c == 0) offer(32'hFFF1_0093, 32'h0, 32'd20, 32'd0);
            else        offer(32'hFFF1_0093, 32'h0, 32'd30, 32'd0);
`else
            exp_rdy = 1'b0;
            offer(32'hFFF1_0093, 32'h0, 32'd20, 32'd0);
`endif
            #1;
            total++; if (out_valid !== 1'b1 || operand1 !== 32'd10) begin bad++; $display("FAIL stall_hold c=%0d got=%b/%h exp=1/a", c, out_valid, operand1); end
            total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL stall_rdy c=%0d got=%b exp=%b", c, in_ready, exp_rdy); end
            step();
        end
        out_ready = 1'b1;
`ifdef IDU_SKID_EN
        step();
        total++; if (out_valid !== 1'b1 || operand1 !== 32'd20 || in_ready !== 1'b1) begin bad++; $display("FAIL skid_first got=%b/%h/%b exp=1/14/1", out_valid, operand1, in_ready); end
        step(); in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || operand1 !== 32'd30) begin bad++; $display("FAIL skid_second got=%b/%h exp=1/1e", out_valid, operand1); end
`else
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_rdy got=%b exp=1", in_ready); end
        step(); in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || operand1 !== 32'd20) begin bad++; $display("FAIL release_next got=%b/%h exp=1/14", out_valid, operand1); end
`endif
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        idle();
        offer(32'hFFF1_0093, 32'h0, 32'd10, 32'd0);
        step();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL flush_pre got=%b exp=1", out_valid); end
        offer(32'hFFF1_0093, 32'h0, 32'd20, 32'd0);
        flush = 1'b1; out_ready = 1'b0;
        step();
        flush = 1'b0; in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_clear got=%b exp=0", out_valid); end
        out_ready = 1'b1;
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_drop got=%b exp=0", out_valid); end
    endtask

    task automatic test_async_reset();
        idle();
        offer(32'hFFF1_0093, 32'h200, 32'd5, 32'd0);
        step();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL arst_pre got=%b exp=1", out_valid); end
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b exp=0", out_valid); end
        total++; if (operand1 !== 32'd0 || operand2 !== 32'd0 || rd !== 5'd0 || wb_en !== 1'b0 || out_pc !== 32'd0) begin bad++; $display("FAIL arst_data got=%h/%h/%0d/%b/%h exp=0", operand1, operand2, rd, wb_en, out_pc); end
        #1 rst_n = 1'b1;
        offer(32'h4020_81B3, 32'h0, 32'd9, 32'd4);
        step(); in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || alu_op !== 4'd1 || operand1 !== 32'd9 || operand2 !== 32'd4 || rd !== 5'd3) begin bad++; $display("FAIL arst_after got=%b/%0d/%h/%h/%0d exp=1/1/9/4/3", out_valid, alu_op, operand1, operand2, rd); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_lui_sub();
        test_srai();
        test_back_to_back();
        test_ebreak_illegal();
        test_stall();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/idu_stage.md
# idu_stage

Registered, handshaked RV32I/RV64I integer decode stage: the parametrised successor to the single-instruction combinational decoder. Accepts one fetched instruction per cycle on a valid/ready interface and drives register-file read addresses combinationally. Samples returned source operands, decodes LUI, AUIPC, JAL, JALR, OP-IMM, OP and EBREAK into ALU operands and control, and presents them to the execute stage from an output register.

## Interface
- DATA_LEN, 32, datapath width; legal values 32 (RV32I) and 64 (RV64I, 6-bit shamt).
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  discard all held and incoming instructions.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  stage can accept this cycle.
- inst  in  32  instruction word.
- pc  in  DATA_LEN  instruction address.
- rs1 / rs2  out  5  register-file read addresses: inst[19:15] / inst[24:20], combinational from inst.
- src1 / src2  in  DATA_LEN  register-file read data, valid in the same cycle as inst.
- out_valid  out  1  decoded instruction available.
- out_ready  in  1  execute accepts.
- rd  out  5  destination register.
- operand1 / operand2  out  DATA_LEN  ALU inputs.
- alu_op  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
- imm  out  DATA_LEN  sign-extended immediate (jump/branch offset for execute).
- out_pc  out  DATA_LEN  pc of decoded instruction.
- wb_en  out  1  write rd.
- is_jump  out  1  JAL or JALR.
- ebreak  out  1  inst == 0x00100073.
- illegal  out  1  unsupported encoding.

## Operation
- Accept = in_valid & in_ready & !flush; accepted instruction is decoded and latched.
- Immediates: I, U, J formats, sign-extended from inst[31] to DATA_LEN.
- LUI: op1=0, op2=imm_U, ADD.
- AUIPC: op1=pc, op2=imm_U, ADD.
- JAL/JALR: op1=pc, op2=4, ADD, is_jump=1, imm=imm_J/imm_I.
- OP-IMM: op1=src1, op2=imm_I. funct3 selects ADD/SLT/SLTU/XOR/OR/AND/SLL/SRL; SRA when inst[30]=1 for funct3=101. Shift op2=shamt zero-extended.
- OP: op1=src1, op2=src2. funct7=0x20 gives SUB (funct3 000) or SRA (funct3 101); other funct7 values except 0x00 are illegal.
- Illegal: unsupported opcode or funct, or shift with inst[25]=1 when DATA_LEN=32. Drives illegal=1, wb_en=0, is_jump=0, op1=op2=imm=0, alu_op=ADD.
- wb_en = legal & !ebreak & rd!=0.

## Timing
- Latency: 1 cycle; an instruction accepted at edge N appears on outputs after edge N.
- Without skid: in_ready = !out_valid | out_ready (combinational).
- Outputs are held stable while out_valid & !out_ready.
- flush has priority: clears out_valid (and skid) at the next edge; an input offered in the flush cycle is dropped.
- Simultaneous drain and accept: the new instruction replaces the old with no bubble.
- Reset: out_valid=0, in_ready=1 (skid variant), all registered outputs 0. Reset mid-stream discards everything.

## Configuration
- IDU_SKID_EN defined: a one-entry skid buffer is added and in_ready becomes a flop (=skid empty), breaking the combinational out_ready→in_ready path.
  - A beat accepted while the output register is stalled goes to the skid.
  - The skid moves to the output register on the next out_ready.
  - Order is preserved.
- IDU_SKID_EN undefined: no skid; in_ready is combinational as above.

## Test plan
- inst 0xFFF10093 (addi x1,x2,-1), src1=5 → next cycle operand1=5, operand2=0xFFFFFFFF (DATA_LEN=32), alu_op=0, rd=1, wb_en=1.
- inst 0x123452B7 (lui x5,0x12345) → operand1=0, operand2=0x12345000, wb_en=1; inst 0x402081B3 (sub x3,x1,x2), src1=9, src2=4 → alu_op=1, operands 9/4.
- inst 0x00100073 → ebreak=1, wb_en=0; inst 0xFFFFFFFF → illegal=1, wb_en=0, operands 0; DATA_LEN=32 inst 0x02009093 (slli shamt 32) → illegal=1.
- out_ready=0 for 3 cycles with in_valid=1 → outputs stable. No skid: in_ready=0. Skid: exactly one extra beat is accepted, then in_ready=0. Release → both delivered in order.
- flush asserted with out_valid=1 and in_valid=1 → next cycle out_valid=0, offered beat not delivered.
- rst_n pulsed low asynchronously mid-stream → out_valid drops immediately, outputs 0; first beat after release decodes correctly.
